// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared by every bit position
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with valid/ready handshakes; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, b_in;
  logic carry, ci_in, fa_s, fa_co, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign ci_in = sub | ci;
`else
  assign b_in = b;
  assign ci_in = ci;
`endif
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(fa_s), .co(fa_co));
  // capture on accept, then one sum bit per RUN cycle into s from the MSB end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      s <= '0;
      c <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      state <= RUN;
      cnt <= '0;
      carry <= ci_in;
      a_sh <= a;
      b_sh <= b_in;
    end else if (state == RUN) begin
      s <= {fa_s, s[WIDTH-1:1]};
      carry <= fa_co;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        state <= DONE;
        c <= fa_co;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the bit-serial adder against plain arithmetic
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ci = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, c, busy;
  logic [W-1:0] s;
  int checks = 0, errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci, input int hold);
    int n;
    logic [W:0] exp;
    exp = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tci};
    @(negedge clk);
    chk("idle_in_ready", {31'b0, in_ready}, 1);
    a = ta; b = tb_v; ci = tci; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, W);
    chk("sum", {23'b0, c, s}, {23'b0, exp});
    chk("busy_done", {31'b0, busy}, 1);
    chk("in_ready_done", {31'b0, in_ready}, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_sum", {23'b0, c, s}, {23'b0, exp});
      chk("hold_in_ready", {31'b0, in_ready}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released_valid", {31'b0, out_valid}, 0);
    chk("released_in_ready", {31'b0, in_ready}, 1);
  endtask

  initial begin
    int prev, nacc;
    logic [W:0] bexp;
    repeat (2) @(negedge clk);
    chk("rst_s", {24'b0, s}, 0);
    chk("rst_c", {31'b0, c}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'hA5, 8'h77, 1'b1, 5);
    @(negedge clk);
    a = 8'hC3; b = 8'h9E; ci = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_out_valid", {31'b0, out_valid}, 0);
    chk("midrun_s", {24'b0, s}, 0);
    chk("midrun_c", {31'b0, c}, 0);
    chk("midrun_busy", {31'b0, busy}, 0);
    chk("midrun_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h80, 8'h80, 1'b1, 0);
    for (int i = 0; i < 10; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    bexp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    in_valid = 1'b1; out_ready = 1'b1;
    prev = -1; nacc = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (in_ready) begin
        if (prev >= 0) chk("spacing", cyc - prev, W + 2);
        prev = cyc;
        nacc++;
      end
      if (out_valid) chk("b2b_sum", {23'b0, c, s}, {23'b0, bexp});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", {31'b0, nacc >= 4}, 1);
    repeat (W + 4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
